arb_core: RTL and testbench
===========================

ARB_CORE -- requirements
Module: arb_core

Interface
REQ-001 SHALL have parameter: DATA_W, 32, word width of channel data.
REQ-002 SHALL have parameter: NUM_CH, 3, number of slave channels (1..4).
REQ-003 SHALL have ports: clk_i  in  1  single clock, all logic on posedge.
REQ-004 SHALL have port: rst_i  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port: slv_req_i  in  NUM_CH  per-channel "FIFO not empty" request.
REQ-006 SHALL have port: slv_val_i  in  NUM_CH  per-channel read-data valid, one cycle after ack.
REQ-007 SHALL have port: slv_data_i  in  NUM_CH*DATA_W  per-channel read data; channel n at bits [n*DATA_W +: DATA_W].
REQ-008 SHALL have port: a2s_ack_o  out  NUM_CH  one-hot single-cycle read strobe to the granted slave.
REQ-009 SHALL have port: prio_i  in  2*NUM_CH  per-channel priority; 0 highest; channel n at [2n+:2].
REQ-010 SHALL have port: a2f_data_o  out  DATA_W  word forwarded downstream.
REQ-011 SHALL have port: a2f_id_o  out  2  source channel index of a2f_data_o.
REQ-012 SHALL have port: a2f_val_o  out  1  downstream valid.
REQ-013 SHALL have port: f2a_ready_i  in  1  downstream ready; transfer when a2f_val_o && f2a_ready_i.
REQ-014 SHALL have port: err_o  out  1  sticky protocol error flag.

Function
REQ-015 SHALL implement FSM IDLE -> ACK -> WAIT -> HOLD -> IDLE.
REQ-016 In IDLE, if any slv_req_i bit is set, SHALL latch winner index into sel and go to ACK next cycle; else stay.
REQ-017 Winner SHALL be the requesting channel with numerically lowest prio_i; equal-priority ties per REQ-027/028.
REQ-018 In ACK, a2s_ack_o SHALL equal one-hot(sel) for exactly one cycle, zero in every other state; then go to WAIT.
REQ-019 In WAIT, if slv_val_i[sel]=1, SHALL capture slv_data_i[sel] into a2f_data_o, sel into a2f_id_o, set a2f_val_o next cycle, go to HOLD.
REQ-020 In WAIT, if slv_val_i[sel]=0, SHALL set err_o and return to IDLE without asserting a2f_val_o.
REQ-021 slv_val_i on a non-selected channel, or outside WAIT, SHALL set err_o and be otherwise ignored.
REQ-022 In HOLD, a2f_data_o/a2f_id_o/a2f_val_o SHALL stay stable until f2a_ready_i=1; on that cycle a2f_val_o clears next edge and FSM goes to IDLE.
REQ-023 Latency: request seen in IDLE at cycle T -> ack at T+1 -> slave val at T+2 -> a2f_val_o at T+3; minimum 4 cycles per word.
REQ-024 prio_i and slv_req_i SHALL be sampled only in IDLE; changes mid-transaction have no effect on the current word.
REQ-025 err_o SHALL remain 1 until reset.

Reset
REQ-026 On rst_i=1 (asynchronous): state=IDLE, sel=0, rr pointer=0, a2s_ack_o=0, a2f_val_o=0, a2f_data_o=0, a2f_id_o=0, err_o=0; a reset mid-transaction abandons the word.

Configuration
REQ-027 With ARB_RR_TIE_EN defined, ties SHALL be broken round-robin: first tied channel above the last granted index, wrapping NUM_CH-1 -> 0; pointer updated on every grant.
REQ-028 Without ARB_RR_TIE_EN, ties SHALL go to the lowest channel index and no pointer register exists.

Structure
REQ-029 Package arb_pkg SHALL hold the FSM state typedef, PRIO_W=2, ID_W=2 and the default NUM_CH.
REQ-030 Winner selection SHALL be a combinational sub-module arb_pick (inputs req, prio, rr pointer; output index and any-valid).

Verification
REQ-031 Single req on ch1, val returned at T+2 with 0xDEADBEEF, ready=1 -> ack[1] at T+1, a2f_data_o=0xDEADBEEF, a2f_id_o=1, val at T+3.
REQ-032 req=3'b111, prio ch0=2, ch1=0, ch2=1 -> grants in order ch1, ch2, ch0 while all requests stay high.
REQ-033 req=3'b101, equal prio, ARB_RR_TIE_EN defined -> grants alternate 0,2,0,2; undefined -> always 0.
REQ-034 f2a_ready_i held 0 for 5 cycles in HOLD -> a2f_data_o/id/val stable, no new ack; ready=1 -> IDLE next cycle.
REQ-035 Omit slv_val_i after ack -> err_o=1 at WAIT+1, no a2f_val_o, next request still served.
REQ-036 Assert rst_i during WAIT -> all outputs 0 immediately, FSM IDLE, captured word discarded.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the priority arbiter
// Contents: arb_state_e FSM encoding, PRIO_W, ID_W, NUM_CH_DEF.
package arb_pkg;

    localparam int PRIO_W     = 2;
    localparam int ID_W       = 2;
    localparam int NUM_CH_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner selection for arb_core
// Optional feature macro: ARB_RR_TIE_EN (round-robin tie break).
// Ports:
//   req_i    in  NUM_CH         per-channel request
//   prio_i   in  PRIO_W*NUM_CH  per-channel priority, 0 highest
//   rr_ptr_i in  ID_W           last granted index (used only for round-robin ties)
//   idx_o    out ID_W           winning channel index
//   any_o    out 1              at least one request present
module arb_pick
    import arb_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic [NUM_CH-1:0]        req_i,
    input  logic [PRIO_W*NUM_CH-1:0] prio_i,
    input  logic [ID_W-1:0]          rr_ptr_i,
    output logic [ID_W-1:0]          idx_o,
    output logic                     any_o
);

    logic [PRIO_W-1:0] min_prio;
    logic [NUM_CH-1:0] tie;

    // Lowest priority value among requesters, then the set of requesters
    // sharing it; the tie set is then resolved to a single index.
    always_comb begin
        min_prio = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_i[i] && (prio_i[i*PRIO_W +: PRIO_W] < min_prio)) begin
                min_prio = prio_i[i*PRIO_W +: PRIO_W];
            end
        end
        tie = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            tie[i] = req_i[i] && (prio_i[i*PRIO_W +: PRIO_W] == min_prio);
        end
        any_o = |req_i;
    end

`ifdef ARB_RR_TIE_EN
    // Scan starting just above the last grant, wrapping NUM_CH-1 -> 0;
    // the last granted channel itself is visited last.
    always_comb begin
        logic found;
        found = 1'b0;
        idx_o = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int ch;
            ch = int'(rr_ptr_i) + k;
            if (ch >= NUM_CH) begin
                ch = ch - NUM_CH;
            end
            if (!found && tie[ch]) begin
                idx_o = ID_W'(ch);
                found = 1'b1;
            end
        end
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr_i;

    // Descending scan so the lowest tied index is the last assignment.
    always_comb begin
        idx_o = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (tie[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/arb_core.sv
// rtl/arb_core.sv - priority arbiter reading one word per grant from slave FIFOs
// Optional feature macro: ARB_RR_TIE_EN (round-robin tie break, adds rr pointer).
// Ports:
//   clk_i        in  1              clock, posedge
//   rst_i        in  1              asynchronous active-high reset
//   slv_req_i    in  NUM_CH         per-channel FIFO-not-empty
//   slv_val_i    in  NUM_CH         per-channel read-data valid (one cycle after ack)
//   slv_data_i   in  NUM_CH*DATA_W  per-channel read data
//   a2s_ack_o    out NUM_CH         one-hot read strobe
//   prio_i       in  2*NUM_CH       per-channel priority, 0 highest
//   a2f_data_o   out DATA_W         forwarded word
//   a2f_id_o     out 2              source channel of forwarded word
//   a2f_val_o    out 1              downstream valid
//   f2a_ready_i  in  1              downstream ready
//   err_o        out 1              sticky protocol error
module arb_core
    import arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_CH-1:0]        slv_req_i,
    input  logic [NUM_CH-1:0]        slv_val_i,
    input  logic [NUM_CH*DATA_W-1:0] slv_data_i,
    output logic [NUM_CH-1:0]        a2s_ack_o,
    input  logic [PRIO_W*NUM_CH-1:0] prio_i,
    output logic [DATA_W-1:0]        a2f_data_o,
    output logic [ID_W-1:0]          a2f_id_o,
    output logic                     a2f_val_o,
    input  logic                     f2a_ready_i,
    output logic                     err_o
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     sel_q,   sel_d;
    logic [NUM_CH-1:0]   ack_q,   ack_d;
    logic [DATA_W-1:0]   data_q,  data_d;
    logic [ID_W-1:0]     id_q,    id_d;
    logic                val_q,   val_d;
    logic                err_q,   err_d;
    logic [ID_W-1:0]     rr_ptr;

    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic [NUM_CH-1:0]   sel_mask;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_val;
    logic [NUM_CH-1:0]   val_ok_mask;

`ifdef ARB_RR_TIE_EN
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    arb_pick #(
        .NUM_CH (NUM_CH)
    ) u_pick (
        .req_i    (slv_req_i),
        .prio_i   (prio_i),
        .rr_ptr_i (rr_ptr),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // Decode the latched selection into a mask and mux the selected lane.
    always_comb begin
        sel_mask = '0;
        sel_data = '0;
        sel_val  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == ID_W'(i)) begin
                sel_mask[i] = 1'b1;
                sel_data    = slv_data_i[i*DATA_W +: DATA_W];
                sel_val     = slv_val_i[i];
            end
        end
        // Read-data valid is legal only on the selected lane while in WAIT.
        val_ok_mask = (state_q == ST_WAIT) ? sel_mask : '0;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ack_d   = '0;
        data_d  = data_q;
        id_d    = id_q;
        val_d   = val_q;
        err_d   = err_q;
`ifdef ARB_RR_TIE_EN
        rr_ptr_d = rr_ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    ack_d   = NUM_CH'(1) << pick_idx;
                    state_d = ST_ACK;
`ifdef ARB_RR_TIE_EN
                    rr_ptr_d = pick_idx;
`endif
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (sel_val) begin
                    data_d  = sel_data;
                    id_d    = sel_q;
                    val_d   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (f2a_ready_i) begin
                    val_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (|(slv_val_i & ~val_ok_mask)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            ack_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef ARB_RR_TIE_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            id_q    <= id_d;
            val_q   <= val_d;
            err_q   <= err_d;
`ifdef ARB_RR_TIE_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign a2s_ack_o  = ack_q;
    assign a2f_data_o = data_q;
    assign a2f_id_o   = id_q;
    assign a2f_val_o  = val_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_arb_core.sv
// tb/tb_arb_core.sv - directed self-checking bench for arb_core
module tb_arb_core;

    logic        clk;
    logic        rst;
    logic [2:0]  slv_req;
    logic [2:0]  slv_val;
    logic [95:0] slv_data;
    logic [2:0]  ack;
    logic [5:0]  prio;
    logic [31:0] a2f_data;
    logic [1:0]  a2f_id;
    logic        a2f_val;
    logic        ready;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] wd [3] = '{32'h1111_0000, 32'hDEAD_BEEF, 32'h2222_0002};

    arb_core #(.DATA_W(32), .NUM_CH(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .slv_req_i   (slv_req),
        .slv_val_i   (slv_val),
        .slv_data_i  (slv_data),
        .a2s_ack_o   (ack),
        .prio_i      (prio),
        .a2f_data_o  (a2f_data),
        .a2f_id_o    (a2f_id),
        .a2f_val_o   (a2f_val),
        .f2a_ready_i (ready),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full word from channel ch with ready held high; req_after is
    // applied right after the ack so a served one-word FIFO can drop out.
    task automatic serve(input int ch, input logic [2:0] req_after);
        logic [2:0] oh;
        oh = 3'b001 << ch;
        step();
        check("ack_grant", 32'(ack), 32'(oh));
        slv_req = req_after;
        step();
        check("ack_clear", 32'(ack), 32'd0);
        check("val_before", 32'(a2f_val), 32'd0);
        slv_val = oh;
        step();
        slv_val = 3'b000;
        check("fwd_val", 32'(a2f_val), 32'd1);
        check("fwd_data", a2f_data, wd[ch]);
        check("fwd_id", 32'(a2f_id), 32'(ch));
        step();
        check("fwd_val_clr", 32'(a2f_val), 32'd0);
    endtask

    initial begin
        int exp_tie [4];
        rst      = 1'b1;
        slv_req  = 3'b000;
        slv_val  = 3'b000;
        slv_data = {32'h2222_0002, 32'hDEAD_BEEF, 32'h1111_0000};
        prio     = 6'b00_00_00;
        ready    = 1'b1;
        #2;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_val", 32'(a2f_val), 32'd0);
        check("rst_data", a2f_data, 32'd0);
        check("rst_id", 32'(a2f_id), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Single request on ch1
        slv_req = 3'b010;
        serve(1, 3'b000);
        check("t1_err", 32'(err), 32'd0);

        // Priorities ch0=2 ch1=0 ch2=1; each FIFO empties after its word
        prio    = 6'b01_00_10;
        slv_req = 3'b111;
        serve(1, 3'b101);
        serve(2, 3'b001);
        serve(0, 3'b000);

        // Downstream stall for 5 cycles in HOLD on ch2
        prio    = 6'b00_00_00;
        slv_req = 3'b100;
        step();
        check("hold_ack", 32'(ack), 32'b100);
        slv_req = 3'b000;
        step();
        slv_val = 3'b100;
        ready   = 1'b0;
        step();
        slv_val = 3'b000;
        slv_req = 3'b001;
        for (int i = 0; i < 5; i++) begin
            check("hold_val", 32'(a2f_val), 32'd1);
            check("hold_data", a2f_data, 32'h2222_0002);
            check("hold_id", 32'(a2f_id), 32'd2);
            check("hold_noack", 32'(ack), 32'd0);
            step();
        end
        ready = 1'b1;
        step();
        slv_req = 3'b000;
        check("hold_release", 32'(a2f_val), 32'd0);
        check("hold_err", 32'(err), 32'd0);

        // Equal-priority tie between ch0 and ch2; last grant was ch2
`ifdef ARB_RR_TIE_EN
        exp_tie = '{0, 2, 0, 2};
`else
        exp_tie = '{0, 0, 0, 0};
`endif
        slv_req = 3'b101;
        for (int k = 0; k < 4; k++) begin
            serve(exp_tie[k], (k == 3) ? 3'b000 : 3'b101);
        end

        // Missing slave valid after ack
        slv_req = 3'b001;
        step();
        check("miss_ack", 32'(ack), 32'b001);
        slv_req = 3'b000;
        step();
        step();
        check("miss_err", 32'(err), 32'd1);
        check("miss_noval", 32'(a2f_val), 32'd0);
        slv_req = 3'b010;
        serve(1, 3'b000);
        check("miss_sticky", 32'(err), 32'd1);

        // Reset asserted during WAIT
        slv_req = 3'b010;
        step();
        slv_req = 3'b000;
        step();
        slv_val = 3'b010;
        rst     = 1'b1;
        #1;
        check("wrst_ack", 32'(ack), 32'd0);
        check("wrst_val", 32'(a2f_val), 32'd0);
        check("wrst_data", a2f_data, 32'd0);
        check("wrst_id", 32'(a2f_id), 32'd0);
        check("wrst_err", 32'(err), 32'd0);
        slv_val = 3'b000;
        step();
        rst = 1'b0;
        step();
        check("wrst_after_val", 32'(a2f_val), 32'd0);
        check("wrst_after_ack", 32'(ack), 32'd0);
        slv_req = 3'b100;
        serve(2, 3'b000);
        check("wrst_err2", 32'(err), 32'd0);

        // Stray valid while IDLE
        slv_val = 3'b001;
        step();
        slv_val = 3'b000;
        check("stray_err", 32'(err), 32'd1);
        check("stray_noack", 32'(ack), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
